// File: rtl/uart_pkg.sv
// Shared parity-mode constants, RX FSM encoding and the parity-select helper
// used by both link directions of the UART parity engine.
package uart_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_DATA = 2'd1,
        RX_PAR  = 2'd2
    } rx_state_e;

    function automatic logic par_sel(input logic xor_bit, input logic [1:0] mode);
        case (mode)
            PAR_EVEN: return xor_bit;
            PAR_ODD:  return ~xor_bit;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/parity_mask_xor.sv
// Masked xor-reduce of a data word over its active length; a length of 0 or
// above DATA_WIDTH selects the full word. The clamped length is exported too.
module parity_mask_xor #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 4
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [LEN_W-1:0]      i_len,
    output logic [LEN_W-1:0]      o_len,
    output logic                  o_xor
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH);

    logic [LEN_W-1:0]      w_len;
    logic [DATA_WIDTH-1:0] w_mask;

    always_comb begin
        if (i_len == '0 || i_len > MAX_LEN) begin
            w_len = MAX_LEN;
        end else begin
            w_len = i_len;
        end
        w_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_mask[i] = (LEN_W'(i) < w_len);
        end
    end

    assign o_len = w_len;
    assign o_xor = ^(i_data & w_mask);

endmodule

// File: rtl/uart_parity_engine.sv
// UART parity unit: registered TX parity generation and a serial RX parity
// checker with its own latched frame configuration.
module uart_parity_engine
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_par_en,
    input  logic [1:0]            i_par_mode,
    input  logic [LEN_W-1:0]      i_data_len,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_load,
    output logic                  o_tx_par_bit,
    output logic                  o_tx_par_vld,
    input  logic                  i_rx_start,
    input  logic                  i_rx_bit,
    input  logic                  i_rx_bit_stb,
    output logic                  o_rx_par_err,
    output logic                  o_rx_chk_done,
    output logic                  o_rx_busy
);

    logic             w_tx_xor;
    logic [LEN_W-1:0] w_len_clamp;

    // The clamped length also feeds the RX config latch.
    parity_mask_xor #(
        .DATA_WIDTH(DATA_WIDTH),
        .LEN_W     (LEN_W)
    ) u_mask (
        .i_data(i_tx_data),
        .i_len (i_data_len),
        .o_len (w_len_clamp),
        .o_xor (w_tx_xor)
    );

    logic r_tx_par_bit, r_tx_par_vld;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_par_bit <= 1'b0;
            r_tx_par_vld <= 1'b0;
        end else begin
            r_tx_par_vld <= i_tx_load;
            if (i_tx_load) begin
                r_tx_par_bit <= i_par_en ? par_sel(w_tx_xor, i_par_mode) : 1'b0;
            end
        end
    end

    assign o_tx_par_bit = r_tx_par_bit;
    assign o_tx_par_vld = r_tx_par_vld;

    rx_state_e        r_state, w_state_nxt;
    logic [LEN_W-1:0] r_cnt, w_cnt_nxt, r_len, w_len_nxt, w_cnt_inc;
    logic             r_acc, w_acc_nxt;
    logic             r_par_en, w_par_en_nxt;
    logic [1:0]       r_par_mode, w_par_mode_nxt;
    logic             r_err, w_err_nxt;
    logic             r_done, w_done_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= RX_IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_acc      <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_mode <= PAR_EVEN;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_len      <= w_len_nxt;
            r_acc      <= w_acc_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_mode <= w_par_mode_nxt;
            r_err      <= w_err_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_len_nxt      = r_len;
        w_acc_nxt      = r_acc;
        w_par_en_nxt   = r_par_en;
        w_par_mode_nxt = r_par_mode;
        w_err_nxt      = r_err;
        w_done_nxt     = 1'b0;
        w_cnt_inc      = r_cnt + 1'b1;

        // Start wins over any strobe in the same cycle and aborts a running frame.
        if (i_rx_start) begin
            w_state_nxt    = RX_DATA;
            w_cnt_nxt      = '0;
            w_acc_nxt      = 1'b0;
            w_err_nxt      = 1'b0;
            w_len_nxt      = w_len_clamp;
            w_par_en_nxt   = i_par_en;
            w_par_mode_nxt = i_par_mode;
        end else begin
            case (r_state)
                RX_DATA: begin
                    if (i_rx_bit_stb) begin
                        w_acc_nxt = r_acc ^ i_rx_bit;
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == r_len) begin
                            if (r_par_en) begin
                                w_state_nxt = RX_PAR;
                            end else begin
                                w_state_nxt = RX_IDLE;
                                w_done_nxt  = 1'b1;
                                w_err_nxt   = 1'b0;
                            end
                        end
                    end
                end
                RX_PAR: begin
                    if (i_rx_bit_stb) begin
                        w_state_nxt = RX_IDLE;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = (i_rx_bit != par_sel(r_acc, r_par_mode));
                    end
                end
                RX_IDLE: ;
                default: w_state_nxt = RX_IDLE;
            endcase
        end
    end

    assign o_rx_par_err  = r_err;
    assign o_rx_chk_done = r_done;
    assign o_rx_busy     = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_parity_engine.sv
// Scoreboard bench for uart_parity_engine: stimulus pushes expected parity
// results, a negedge monitor pops them whenever a valid/done pulse appears.
module tb_uart_parity_engine;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       par_en;
    logic [1:0] par_mode;
    logic [3:0] data_len;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_par_bit, tx_par_vld;
    logic       rx_start, rx_bit, rx_bit_stb;
    logic       rx_par_err, rx_chk_done, rx_busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit tx_q[$];
    bit rx_q[$];

    always #5 clk = ~clk;

    uart_parity_engine #(
        .DATA_WIDTH(8),
        .LEN_W     (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_par_en     (par_en),
        .i_par_mode   (par_mode),
        .i_data_len   (data_len),
        .i_tx_data    (tx_data),
        .i_tx_load    (tx_load),
        .o_tx_par_bit (tx_par_bit),
        .o_tx_par_vld (tx_par_vld),
        .i_rx_start   (rx_start),
        .i_rx_bit     (rx_bit),
        .i_rx_bit_stb (rx_bit_stb),
        .o_rx_par_err (rx_par_err),
        .o_rx_chk_done(rx_chk_done),
        .o_rx_busy    (rx_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every TX valid / RX done pulse must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_par_vld) begin
                check("tx_vld_expected", int'(tx_q.size() != 0), 1);
                if (tx_q.size() != 0) check("tx_par_bit", int'(tx_par_bit), int'(tx_q.pop_front()));
            end
            if (rx_chk_done) begin
                check("rx_done_expected", int'(rx_q.size() != 0), 1);
                if (rx_q.size() != 0) check("rx_par_err", int'(rx_par_err), int'(rx_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_issue(input logic [7:0] d, input logic [3:0] len, input logic en,
                            input logic [1:0] mode, input bit exp);
        tx_data  = d;
        data_len = len;
        par_en   = en;
        par_mode = mode;
        tx_load  = 1'b1;
        tx_q.push_back(exp);
        cyc();
        tx_load  = 1'b0;
    endtask

    task automatic rx_begin(input logic [3:0] len, input logic en, input logic [1:0] mode);
        data_len = len;
        par_en   = en;
        par_mode = mode;
        rx_start = 1'b1;
        cyc();
        rx_start = 1'b0;
    endtask

    task automatic rx_send(input logic b);
        rx_bit     = b;
        rx_bit_stb = 1'b1;
        cyc();
        rx_bit_stb = 1'b0;
    endtask

    function automatic int all_outs();
        return int'({tx_par_bit, tx_par_vld, rx_par_err, rx_chk_done, rx_busy});
    endfunction

    logic [6:0] f7;
    logic [7:0] f8;
    logic [7:0] txv[8];
    bit         txe[8];

    initial begin
        rst_n = 1'b0; par_en = 1'b0; par_mode = PAR_EVEN; data_len = 4'd8;
        tx_data = '0; tx_load = 1'b0; rx_start = 1'b0; rx_bit = 1'b0; rx_bit_stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        cyc();
        check("post_reset_outputs", all_outs(), 0);

        // TX: A5 has four ones; back-to-back loads
        tx_issue(8'hA5, 4'd8, 1'b1, PAR_EVEN, 1'b0);
        tx_issue(8'hA5, 4'd8, 1'b1, PAR_ODD, 1'b1);
        cyc();
        tx_issue(8'hFF, 4'd5, 1'b1, PAR_EVEN, 1'b1);
        tx_issue(8'hFF, 4'd0, 1'b1, PAR_EVEN, 1'b0);
        tx_issue(8'hFF, 4'd5, 1'b1, PAR_MARK, 1'b1);
        tx_issue(8'hFF, 4'd5, 1'b1, PAR_SPACE, 1'b0);
        tx_issue(8'hA5, 4'd8, 1'b0, PAR_ODD, 1'b0);
        tx_issue(8'h01, 4'd12, 1'b1, PAR_EVEN, 1'b1);
        tx_issue(8'h1F, 4'd4, 1'b1, PAR_ODD, 1'b1);
        repeat (3) cyc();
        check("tx_bit_held", int'(tx_par_bit), 1);
        check("tx_vld_idle", int'(tx_par_vld), 0);

        // RX odd, LEN=7, bits 1011001 (four ones): good then bad parity
        f7 = 7'b1001101;
        rx_begin(4'd7, 1'b1, PAR_ODD);
        check("rx_busy_after_start", int'(rx_busy), 1);
        for (int i = 0; i < 7; i++) rx_send(f7[i]);
        rx_q.push_back(1'b0);
        rx_send(1'b1);
        cyc();
        rx_begin(4'd7, 1'b1, PAR_ODD);
        for (int i = 0; i < 7; i++) rx_send(f7[i]);
        rx_q.push_back(1'b1);
        rx_send(1'b0);
        repeat (4) cyc();
        check("rx_err_held", int'(rx_par_err), 1);
        check("rx_idle_busy", int'(rx_busy), 0);
        rx_begin(4'd7, 1'b1, PAR_ODD);
        check("rx_err_cleared_by_start", int'(rx_par_err), 0);

        // RX without parity, LEN=8 (aborts the open frame above)
        f8 = 8'b0000_0111;
        rx_begin(4'd8, 1'b0, PAR_EVEN);
        for (int i = 0; i < 7; i++) rx_send(f8[i]);
        rx_q.push_back(1'b0);
        rx_send(f8[7]);
        check("rx_noparity_done_now", int'(rx_chk_done), 1);
        check("rx_noparity_busy", int'(rx_busy), 0);
        rx_send(1'b1);
        rx_send(1'b0);
        rx_send(1'b1);
        check("rx_idle_strobes_busy", int'(rx_busy), 0);

        // Abort after 4 bits with a simultaneous strobe; new frame from clean acc
        rx_begin(4'd8, 1'b1, PAR_EVEN);
        rx_send(1'b1); rx_send(1'b0); rx_send(1'b0); rx_send(1'b0);
        rx_bit = 1'b1;
        rx_bit_stb = 1'b1;
        rx_begin(4'd8, 1'b1, PAR_EVEN);
        rx_bit_stb = 1'b0;
        par_mode = PAR_ODD;
        par_en   = 1'b0;
        f8 = 8'b1000_0011;
        for (int i = 0; i < 8; i++) rx_send(f8[i]);
        check("rx_wait_parity_busy", int'(rx_busy), 1);
        rx_q.push_back(1'b0);
        rx_send(1'b1);
        cyc();

        // Reset mid-frame with a TX load pending
        tx_issue(8'h01, 4'd8, 1'b1, PAR_EVEN, 1'b1);
        rx_begin(4'd8, 1'b1, PAR_EVEN);
        rx_send(1'b1); rx_send(1'b1); rx_send(1'b0);
        check("busy_before_reset", int'(rx_busy), 1);
        tx_data = 8'h01; tx_load = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("outputs_in_reset", all_outs(), 0);
        @(posedge clk);
        #1 check("outputs_after_reset_edge", all_outs(), 0);
        tx_load = 1'b0;
        rst_n = 1'b1;
        cyc();

        // Concurrent TX loads while an RX odd frame of 3C streams in
        txv = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        txe = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        f8  = 8'h3C;
        rx_begin(4'd8, 1'b1, PAR_ODD);
        for (int i = 0; i < 8; i++) begin
            tx_data = txv[i]; data_len = 4'd8; par_en = 1'b1; par_mode = PAR_EVEN;
            tx_load = 1'b1; tx_q.push_back(txe[i]);
            rx_bit = f8[i]; rx_bit_stb = 1'b1;
            cyc();
        end
        tx_data = 8'h00; tx_q.push_back(1'b0);
        rx_bit = 1'b1; rx_q.push_back(1'b0);
        cyc();
        tx_load = 1'b0; rx_bit_stb = 1'b0;

        for (int i = 0; i < 20 && (tx_q.size() != 0 || rx_q.size() != 0); i++) cyc();
        check("tx_queue_drained", tx_q.size(), 0);
        check("rx_queue_drained", rx_q.size(), 0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
